// File: rtl/toffoli_pkg.sv
// Shared types and helpers for the serial masked chi-row controller.
package toffoli_pkg;

  // Controller states; the encoding is also exported on the debug port.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_GAP   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // One masked bit as a share pair {s1, s0}.
  typedef logic [1:0] share_pair_t;

  // Generic index width; it covers row widths up to 32 plus the wrap headroom.
  localparam int IDX_W = 6;

  // (i + k) mod n for i < n and k < n, using compare-and-subtract instead of a divider.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] i,
                                                input logic [IDX_W-1:0] k,
                                                input logic [IDX_W-1:0] n);
    logic [IDX_W:0] s;
    s = {1'b0, i} + {1'b0, k};
    if (s >= {1'b0, n}) s = s - {1'b0, n};
    return s[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/toffoli_chi_row_wrap.sv
// Wrapper pairing the chi-row controller with a one-cycle two-share
// Toffoli-chi gadget, exposing only the row handshake.
module toffoli_chi_row_wrap
  import toffoli_pkg::*;
#(
  parameter int N      = 5,
  parameter int BUBBLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_s0,
  input  logic [N-1:0] in_s1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_s0,
  output logic [N-1:0] out_s1,
  output state_e       dbg_state
);

  share_pair_t tof_a, tof_b, tof_c;
  share_pair_t tof_res_q;

  toffoli_chi_row_seq #(.N(N), .BUBBLE(BUBBLE)) u_seq (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s0     (in_s0),
    .in_s1     (in_s1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s0    (out_s0),
    .out_s1    (out_s1),
    .tof_a     (tof_a),
    .tof_b     (tof_b),
    .tof_c     (tof_c),
    .tof_res   (tof_res_q),
    .dbg_state (dbg_state)
  );

  // Functional gadget: a ^ (~b & c) with ~b applied to share 0 only; a hardened
  // gadget with fresh randomness can replace this block with the same timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      tof_res_q <= '0;
    end else begin
      tof_res_q[0] <= tof_a[0] ^ (~tof_b[0] & tof_c[0]) ^ (~tof_b[0] & tof_c[1]);
      tof_res_q[1] <= tof_a[1] ^ (tof_b[1] & tof_c[0]) ^ (tof_b[1] & tof_c[1]);
    end
  end

endmodule

// File: rtl/toffoli_chi_row_seq.sv
// Serial controller: evaluates one masked chi row, one bit-operation per issue
// slot, through a single external two-share Toffoli-chi gadget.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; valid never depends on ready, and data is held stable while valid is high
// and ready is low.
module toffoli_chi_row_seq
  import toffoli_pkg::*;
#(
  parameter int N      = 5,
  parameter int BUBBLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_s0,
  input  logic [N-1:0] in_s1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_s0,
  output logic [N-1:0] out_s1,
  output share_pair_t  tof_a,
  output share_pair_t  tof_b,
  output share_pair_t  tof_c,
  input  share_pair_t  tof_res,
  output state_e       dbg_state
);

  localparam int IW = $clog2(N);

  state_e         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [IW-1:0]  idx_p1, idx_p2;
  logic [N-1:0]   row_s0_q, row_s0_d;
  logic [N-1:0]   row_s1_q, row_s1_d;
  logic [N-1:0]   res_s0_q, res_s1_q;
  logic           issue;
  logic           issue_q;
  logic [IW-1:0]  cap_idx_q;

  // Neighbour indices (i+1) and (i+2) modulo N for the current issue.
  assign idx_p1 = IW'(wrap_add(IDX_W'(idx_q), IDX_W'(1), IDX_W'(N)));
  assign idx_p2 = IW'(wrap_add(IDX_W'(idx_q), IDX_W'(2), IDX_W'(N)));

  // The result register is always visible; out_valid alone gates its meaning.
  assign out_s0    = res_s0_q;
  assign out_s1    = res_s1_q;
  assign dbg_state = state_q;

  // Next-state and outputs; gadget operands are zero outside ISSUE so no two
  // operations ever share a cycle on the gadget inputs.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    row_s0_d  = row_s0_q;
    row_s1_d  = row_s1_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    issue     = 1'b0;
    tof_a     = '0;
    tof_b     = '0;
    tof_c     = '0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          row_s0_d = in_s0;
          row_s1_d = in_s1;
          idx_d    = '0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        issue = 1'b1;
        tof_a = {row_s1_q[idx_q],  row_s0_q[idx_q]};
        tof_b = {row_s1_q[idx_p1], row_s0_q[idx_p1]};
        tof_c = {row_s1_q[idx_p2], row_s0_q[idx_p2]};
        if (idx_q == IW'(N - 1)) begin
          state_d = ST_DRAIN;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = (BUBBLE != 0) ? ST_GAP : ST_ISSUE;
        end
      end
      ST_GAP:   state_d = ST_ISSUE;
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, index and operand row registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      row_s0_q <= '0;
      row_s1_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      row_s0_q <= row_s0_d;
      row_s1_q <= row_s1_d;
    end
  end

  // Gadget result capture one cycle after each issue, independent of state.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_q   <= 1'b0;
      cap_idx_q <= '0;
      res_s0_q  <= '0;
      res_s1_q  <= '0;
    end else begin
      issue_q   <= issue;
      cap_idx_q <= idx_q;
      if (issue_q) begin
        res_s0_q[cap_idx_q] <= tof_res[0];
        res_s1_q[cap_idx_q] <= tof_res[1];
      end
    end
  end

endmodule

// File: tb/tb_toffoli_chi_row_seq.sv
// Bench for the chi-row controller: two instances (back-to-back and bubbled
// issue) driven against a bench-side gadget and a chi reference model.
module tb_toffoli_chi_row_seq;
  import toffoli_pkg::*;

  localparam int N = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid  [2];
  logic         in_ready  [2];
  logic [N-1:0] in_s0     [2];
  logic [N-1:0] in_s1     [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [N-1:0] out_s0    [2];
  logic [N-1:0] out_s1    [2];
  share_pair_t  tof_a     [2];
  share_pair_t  tof_b     [2];
  share_pair_t  tof_c     [2];
  share_pair_t  tof_res   [2];
  state_e       dbg_state [2];

  toffoli_chi_row_seq #(.N(N), .BUBBLE(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_s0(in_s0[0]), .in_s1(in_s1[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_s0(out_s0[0]), .out_s1(out_s1[0]),
    .tof_a(tof_a[0]), .tof_b(tof_b[0]), .tof_c(tof_c[0]),
    .tof_res(tof_res[0]), .dbg_state(dbg_state[0])
  );

  toffoli_chi_row_seq #(.N(N), .BUBBLE(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_s0(in_s0[1]), .in_s1(in_s1[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_s0(out_s0[1]), .out_s1(out_s1[1]),
    .tof_a(tof_a[1]), .tof_b(tof_b[1]), .tof_c(tof_c[1]),
    .tof_res(tof_res[1]), .dbg_state(dbg_state[1])
  );

  // Bench gadget: recombined a ^ (~b & c), re-split with a fresh random mask.
  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      logic m, r;
      m = 1'($urandom);
      r = (tof_a[b][0] ^ tof_a[b][1]) ^
          (~(tof_b[b][0] ^ tof_b[b][1]) & (tof_c[b][0] ^ tof_c[b][1]));
      tof_res[b] <= {m ^ r, m};
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [N-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] chi_ref(input logic [N-1:0] a);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++)
      r[i] = a[i] ^ (~a[(i + 1) % N] & a[(i + 2) % N]);
    return r;
  endfunction

  // Cycle k after acceptance (k=1 is the first cycle) carries an issue?
  function automatic bit is_issue(input int b, input int k);
    if (b == 0) return (k >= 1) && (k <= N);
    return (k % 2 == 1) && (k <= 2 * N - 1);
  endfunction

  function automatic int issue_bit(input int b, input int k);
    return (b == 0) ? (k - 1) : ((k - 1) / 2);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic accept_row(input int b, input logic [N-1:0] s0, input logic [N-1:0] s1);
    int w;
    w = 0;
    while (!in_ready[b] && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_idle", 32'(in_ready[b]), 32'd1);
    in_valid[b] = 1'b1;
    in_s0[b]    = s0;
    in_s1[b]    = s1;
    @(posedge clk);
    @(negedge clk);
    in_valid[b] = 1'b0;
    in_s0[b]    = N'($urandom);
    in_s1[b]    = N'($urandom);
  endtask

  task automatic run_row(input int b, input logic [N-1:0] row, input logic [N-1:0] mask,
                         input int bp);
    logic [N-1:0] s0, s1, g0, g1, exp;
    int kdone, j, j1, j2;
    s1 = mask;
    s0 = row ^ mask;
    g0 = '0;
    g1 = '0;
    exp_q.push_back(chi_ref(row));
    kdone = (b == 0) ? N + 2 : 2 * N + 1;
    accept_row(b, s0, s1);
    for (int k = 1; k <= kdone; k++) begin
      if (k > 1 && is_issue(b, k - 1)) begin
        j = issue_bit(b, k - 1);
        g0[j] = tof_res[b][0];
        g1[j] = tof_res[b][1];
      end
      if (is_issue(b, k)) begin
        j  = issue_bit(b, k);
        j1 = (j + 1) % N;
        j2 = (j + 2) % N;
        check("tof_a", 32'(tof_a[b]), 32'({s1[j], s0[j]}));
        check("tof_b", 32'(tof_b[b]), 32'({s1[j1], s0[j1]}));
        check("tof_c", 32'(tof_c[b]), 32'({s1[j2], s0[j2]}));
      end else begin
        check("tof_idle_zero", 32'({tof_a[b], tof_b[b], tof_c[b]}), 32'd0);
      end
      check("in_ready_busy", 32'(in_ready[b]), 32'd0);
      check("out_valid_timing", 32'(out_valid[b]), 32'(k == kdone));
      if (k < kdone) @(negedge clk);
    end
    exp = exp_q.pop_front();
    check("recombined", 32'(out_s0[b] ^ out_s1[b]), 32'(exp));
    check("out_s0", 32'(out_s0[b]), 32'(g0));
    check("out_s1", 32'(out_s1[b]), 32'(g1));
    for (int i = 1; i < bp; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid[b]), 32'd1);
      check("hold_s0", 32'(out_s0[b]), 32'(g0));
      check("hold_s1", 32'(out_s1[b]), 32'(g1));
      check("hold_in_ready", 32'(in_ready[b]), 32'd0);
    end
    out_ready[b] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[b] = 1'b0;
    check("consumed_valid", 32'(out_valid[b]), 32'd0);
    check("consumed_in_ready", 32'(in_ready[b]), 32'd1);
  endtask

  task automatic check_reset_state(input int b);
    check("rst_state", 32'(dbg_state[b]), 32'(ST_IDLE));
    check("rst_in_ready", 32'(in_ready[b]), 32'd1);
    check("rst_out_valid", 32'(out_valid[b]), 32'd0);
    check("rst_out", 32'({out_s1[b], out_s0[b]}), 32'd0);
    check("rst_tof", 32'({tof_a[b], tof_b[b], tof_c[b]}), 32'd0);
  endtask

  // Abort a row on the back-to-back instance during its third issue.
  task automatic abort_row();
    accept_row(0, 5'h05 ^ 5'h0A, 5'h0A);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_state(0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_valid", 32'(out_valid[0]), 32'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int b = 0; b < 2; b++) begin
      in_valid[b]  = 1'b0;
      in_s0[b]     = '0;
      in_s1[b]     = '0;
      out_ready[b] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state(0);
    check_reset_state(1);
    rst = 1'b0;
    @(negedge clk);

    run_row(0, 5'h01, 5'h00, 0);
    check("directed_0x01", 32'(out_s0[0] ^ out_s1[0]), 32'h09);
    run_row(1, 5'h02, 5'h15, 0);
    check("directed_0x02", 32'(out_s0[1] ^ out_s1[1]), 32'h12);
    run_row(0, 5'h1F, N'($urandom), 0);
    run_row(1, 5'h00, N'($urandom), 0);
    run_row(1, 5'h1F, N'($urandom), 4);
    run_row(0, 5'h00, N'($urandom), 4);

    abort_row();
    run_row(0, 5'h01, 5'h00, 0);
    check("after_abort_0x01", 32'(out_s0[0] ^ out_s1[0]), 32'h09);

    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 32; r++)
        for (int m = 0; m < 4; m++)
          run_row(b, N'(r), N'($urandom), int'($urandom_range(0, 3)));

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog so a stuck handshake cannot hang the run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
